// File: rtl/tbird_lamp_sequencer_pkg.sv
// Shared types for the Thunderbird tail-lamp sequencer.
//   state_t : sequencer states
//   MODE_*  : encodings reported on the mode output
//   lamps_t : the six lamp drives, left outer..inner then right inner..outer
//   mode_of : maps a state to its mode code
package tbird_pkg;

  typedef enum logic [3:0] {
    IDLE,
    L1,
    L2,
    L3,
    R1,
    R2,
    R3,
    HZ,
    OFF
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  typedef struct packed {
    logic lc;
    logic lb;
    logic la;
    logic ra;
    logic rb;
    logic rc;
  } lamps_t;

  // OFF is the dark gap between flashes; it belongs to no particular
  // direction, so it reports the idle code like IDLE does.
  function automatic logic [1:0] mode_of(state_t s);
    case (s)
      L1, L2, L3: return MODE_LEFT;
      R1, R2, R3: return MODE_RIGHT;
      HZ:         return MODE_HAZ;
      default:    return MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tbird_lamp_sequencer_if.sv
// Request/lamp bundle between the switch layer and the lamp sequencer.
//   left, right, hazard, brake : level requests from the switch layer
//   la, lb, lc                 : left lamps, inner to outer
//   ra, rb, rc                 : right lamps, inner to outer
//   busy                       : sequencer not idle
//   mode                       : 0 idle, 1 left, 2 right, 3 hazard
// master = switch layer side, slave = sequencer side.
interface tbird_lamp_sequencer_if;
  import tbird_pkg::*;

  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic       la;
  logic       lb;
  logic       lc;
  logic       ra;
  logic       rb;
  logic       rc;
  logic       busy;
  logic [1:0] mode;

  modport master (
    output left, right, hazard, brake,
    input  la, lb, lc, ra, rb, rc, busy, mode
  );

  modport slave (
    input  left, right, hazard, brake,
    output la, lb, lc, ra, rb, rc, busy, mode
  );

endinterface

// File: rtl/tbird_lamp_sequencer_step_timer.sv
// Step prescaler: counts 0..TICK_DIV-1 while run is high and flags the last
// count with tick.
//   clk   : clock
//   reset : synchronous active-high reset
//   clear : restart the count at 0 next cycle (state change)
//   run   : count enable; count held at 0 while low
//   tick  : high on the final cycle of a step
module tbird_step_timer #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  // A one-cycle step still needs a (single, constant-zero) count bit.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  // With TICK_DIV=1 LAST is 0, so tick stays high for as long as run is.
  assign tick = run && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || !run || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/tbird_lamp_sequencer.sv
// Thunderbird tail-lamp sequencer. Arbitrates left/right/hazard requests,
// steps the lamps once every TICK_DIV clocks and overlays the brake lamps.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : request inputs and lamp/status outputs (slave side)
module tbird_lamp_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  tbird_lamp_sequencer_if.slave       bus
);
  import tbird_pkg::*;

  state_t state_reg;
  state_t state_next;
  state_t req;
  logic   brake_q_reg;
  logic   tick;
  logic   run;
  logic   clear;
  lamps_t lamps;
  logic   left_seq;
  logic   right_seq;

  // Priority decode: hazard, or both turn switches at once, outranks a
  // single direction.
  function automatic state_t decode(logic l, logic r, logic h);
    if (h || (l && r)) return HZ;
    else if (l)        return L1;
    else if (r)        return R1;
    else               return IDLE;
  endfunction

  assign req   = decode(bus.left, bus.right, bus.hazard);
  assign run   = (state_reg != IDLE);
  // Every state change restarts the step so each state lasts a full step.
  assign clear = (state_next != state_reg);

  tbird_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .run   (run),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      brake_q_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      brake_q_reg <= bus.brake;
    end
  end

  // Turn sequences only yield to hazard on a step boundary; a dropped
  // turn request never aborts, the sequence runs on through OFF.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = req;
      L1:   if (tick) state_next = (req == HZ) ? HZ : L2;
      L2:   if (tick) state_next = (req == HZ) ? HZ : L3;
      L3:   if (tick) state_next = (req == HZ) ? HZ : OFF;
      R1:   if (tick) state_next = (req == HZ) ? HZ : R2;
      R2:   if (tick) state_next = (req == HZ) ? HZ : R3;
      R3:   if (tick) state_next = (req == HZ) ? HZ : OFF;
      HZ:   if (tick) state_next = OFF;
      OFF:  if (tick) state_next = req;
      default: state_next = IDLE;
    endcase
  end

  assign left_seq  = (state_reg == L1) || (state_reg == L2) || (state_reg == L3);
  assign right_seq = (state_reg == R1) || (state_reg == R2) || (state_reg == R3);

  always_comb begin
    lamps = '0;
    case (state_reg)
      L1: lamps.la = 1'b1;
      L2: begin lamps.la = 1'b1; lamps.lb = 1'b1; end
      L3: begin lamps.la = 1'b1; lamps.lb = 1'b1; lamps.lc = 1'b1; end
      R1: lamps.ra = 1'b1;
      R2: begin lamps.ra = 1'b1; lamps.rb = 1'b1; end
      R3: begin lamps.ra = 1'b1; lamps.rb = 1'b1; lamps.rc = 1'b1; end
      HZ: lamps = '1;
      default: lamps = '0;
    endcase
    // Brake lights whichever side is not busy signalling a turn.
    if (brake_q_reg && (state_reg != HZ)) begin
      if (!left_seq) begin
        lamps.la = 1'b1;
        lamps.lb = 1'b1;
        lamps.lc = 1'b1;
      end
      if (!right_seq) begin
        lamps.ra = 1'b1;
        lamps.rb = 1'b1;
        lamps.rc = 1'b1;
      end
    end
  end

  assign bus.la   = lamps.la;
  assign bus.lb   = lamps.lb;
  assign bus.lc   = lamps.lc;
  assign bus.ra   = lamps.ra;
  assign bus.rb   = lamps.rb;
  assign bus.rc   = lamps.rc;
  assign bus.busy = run;
  assign bus.mode = mode_of(state_reg);

endmodule

// File: tb/tb_tbird_lamp_sequencer.sv
// Bench for tbird_lamp_sequencer: one instance with TICK_DIV=2 and one with
// TICK_DIV=1 share clock, reset and requests. Each is tracked by a model
// that keeps the active sequence kind and the cycle position inside it.
module tb_tbird_lamp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tbird_lamp_sequencer_if bus0();
  tbird_lamp_sequencer_if bus1();

  tbird_lamp_sequencer #(.TICK_DIV(2)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
  tbird_lamp_sequencer #(.TICK_DIV(1)) dut1 (.clk(clk), .reset(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int td [2] = '{2, 1};

  bit in_l, in_r, in_h, in_b, in_rst;

  // Model: kind 0 none, 1 left, 2 right, 3 hazard; pos counts clocks
  // since the sequence began (turn: 4 steps incl. dark, hazard: 2 steps).
  int m_kind  [2];
  int m_pos   [2];
  bit m_brake [2];

  task automatic apply();
    rst         = in_rst;
    bus0.left   = in_l; bus0.right = in_r; bus0.hazard = in_h; bus0.brake = in_b;
    bus1.left   = in_l; bus1.right = in_r; bus1.hazard = in_h; bus1.brake = in_b;
  endtask

  task automatic model_update(input int i);
    int req, len, t;
    t = td[i];
    if (in_rst) begin
      m_kind[i] = 0; m_pos[i] = 0; m_brake[i] = 0;
    end else begin
      req = (in_h || (in_l && in_r)) ? 3 : in_l ? 1 : in_r ? 2 : 0;
      if (m_kind[i] == 0) begin
        m_kind[i] = req; m_pos[i] = 0;
      end else begin
        len = (m_kind[i] == 3) ? 2 * t : 4 * t;
        if (m_pos[i] == len - 1) begin
          m_kind[i] = req; m_pos[i] = 0;
        end else if (m_kind[i] != 3 && m_pos[i] < 3 * t &&
                     (m_pos[i] % t) == t - 1 && req == 3) begin
          m_kind[i] = 3; m_pos[i] = 0;
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
      m_brake[i] = in_b;
    end
  endtask

  // {la,lb,lc, ra,rb,rc, busy, mode}
  function automatic logic [8:0] exp_out(int i);
    int p, t, k, n;
    logic [2:0] lft, rgt;
    logic [1:0] md;
    bit lseq, rseq, hzon;
    p = m_pos[i]; t = td[i]; k = m_kind[i];
    lft = 3'b000; rgt = 3'b000; md = 2'd0;
    lseq = 0; rseq = 0; hzon = 0;
    if ((k == 1 || k == 2) && p < 3 * t) begin
      n = p / t + 1;
      if (k == 1) begin lft = {1'b1, n >= 2, n >= 3}; lseq = 1; md = 2'd1; end
      else        begin rgt = {1'b1, n >= 2, n >= 3}; rseq = 1; md = 2'd2; end
    end else if (k == 3 && p < t) begin
      lft = 3'b111; rgt = 3'b111; md = 2'd3; hzon = 1;
    end
    if (m_brake[i] && !hzon) begin
      if (!lseq) lft = 3'b111;
      if (!rseq) rgt = 3'b111;
    end
    return {lft, rgt, k != 0, md};
  endfunction

  function automatic logic [8:0] obs(int i);
    if (i == 0) return {bus0.la, bus0.lb, bus0.lc, bus0.ra, bus0.rb, bus0.rc, bus0.busy, bus0.mode};
    return {bus1.la, bus1.lb, bus1.lc, bus1.ra, bus1.rb, bus1.rc, bus1.busy, bus1.mode};
  endfunction

  // Advance one clock: inputs are stable across the edge, model follows the
  // edge, outputs are then read on the falling edge.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_l = 0; in_r = 0; in_h = 0; in_b = 0; in_rst = 1; apply();
    step();
    in_rst = 0; apply();
  endtask

  task automatic test_reset();
    logic [8:0] got;
    in_l = 1; in_r = 1; in_h = 1; in_b = 1; in_rst = 1; apply();
    step(); step();
    for (int i = 0; i < 2; i++) begin
      got = obs(i); checks++;
      if (got !== 9'b000000_0_00) begin
        errors++; $display("FAIL reset_state inst%0d got %b want %b", i, got, 9'b000000_0_00);
      end
    end
    in_rst = 0; apply();
    step();
    for (int i = 0; i < 2; i++) begin
      got = obs(i); checks++;
      if (got !== 9'b111111_1_11) begin
        errors++; $display("FAIL reset_first_hz inst%0d got %b want %b", i, got, 9'b111111_1_11);
      end
    end
  endtask

  task automatic test_left();
    logic [8:0] got, want;
    logic [2:0] pat [4] = '{3'b100, 3'b110, 3'b111, 3'b000};
    int p, cnt;
    do_reset();
    in_l = 1; apply();
    for (int k = 0; k < 16; k++) begin
      step();
      p = k % 8;
      want = {pat[p / 2], 3'b000, 1'b1, (p < 6) ? 2'd1 : 2'd0};
      got = obs(0); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_pattern cyc%0d got %b want %b", k, got, want);
      end
      got = obs(1); want = exp_out(1); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_model_td1 cyc%0d got %b want %b", k, got, want);
      end
    end
    // Drop left as soon as L2 is entered; busy must fall 6 edges later.
    do_reset();
    in_l = 1; apply();
    step(); step(); step();
    in_l = 0; apply();
    cnt = 0;
    while (bus0.busy && cnt < 12) begin
      step(); cnt++;
      got = obs(0); want = exp_out(0); checks++;
      if (got !== want) begin
        errors++; $display("FAIL left_drop cyc%0d got %b want %b", cnt, got, want);
      end
    end
    checks++;
    if (cnt !== 6) begin
      errors++; $display("FAIL left_drop_busy_fall got %0d cycles want 6", cnt);
    end
  endtask

  task automatic test_hazard_pair();
    logic [8:0] got, want;
    do_reset();
    in_l = 1; in_r = 1; apply();
    for (int k = 0; k < 12; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        got = obs(i); want = exp_out(i); checks++;
        if (got !== want) begin
          errors++; $display("FAIL hazard_pair inst%0d cyc%0d got %b want %b", i, k, got, want);
        end
      end
      got = obs(0); checks++;
      want = ((k % 4) < 2) ? 9'b111111_1_11 : 9'b000000_1_00;
      if (got !== want) begin
        errors++; $display("FAIL hazard_pair_td2 cyc%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_preempt();
    logic [8:0] got, want;
    // Hazard on the tick cycle of R2 -> HZ.
    do_reset();
    in_r = 1; apply();
    step(); step(); step(); step();
    in_h = 1; apply();
    step();
    got = obs(0); checks++;
    if (got !== 9'b111111_1_11) begin
      errors++; $display("FAIL preempt_tick got %b want %b", got, 9'b111111_1_11);
    end
    got = obs(1); want = exp_out(1); checks++;
    if (got !== want) begin
      errors++; $display("FAIL preempt_tick_td1 got %b want %b", got, want);
    end
    // Hazard only on the first (non-tick) cycle of R2 -> R3 as usual.
    do_reset();
    in_r = 1; apply();
    step(); step(); step();
    in_h = 1; apply();
    step();
    in_h = 0; apply();
    step();
    got = obs(0); checks++;
    if (got !== 9'b000111_1_10) begin
      errors++; $display("FAIL preempt_nontick got %b want %b", got, 9'b000111_1_10);
    end
    got = obs(1); want = exp_out(1); checks++;
    if (got !== want) begin
      errors++; $display("FAIL preempt_nontick_td1 got %b want %b", got, want);
    end
  endtask

  task automatic test_brake();
    logic [8:0] got, want;
    do_reset();
    in_b = 1; apply();
    got = obs(0); checks++;
    if (got !== 9'b000000_0_00) begin
      errors++; $display("FAIL brake_delay got %b want %b", got, 9'b000000_0_00);
    end
    step();
    got = obs(0); checks++;
    if (got !== 9'b111111_0_00) begin
      errors++; $display("FAIL brake_idle got %b want %b", got, 9'b111111_0_00);
    end
    do_reset();
    in_b = 1; in_l = 1; apply();
    for (int k = 0; k < 8; k++) begin
      step();
      got = obs(0); want = exp_out(0); checks++;
      if (got !== want || (k < 6 && got[5:3] !== 3'b111)) begin
        errors++; $display("FAIL brake_left cyc%0d got %b want %b", k, got, want);
      end
    end
    do_reset();
    in_b = 1; in_l = 0; in_h = 1; apply();
    step();
    got = obs(0); checks++;
    if (got !== 9'b111111_1_11) begin
      errors++; $display("FAIL brake_hazard got %b want %b", got, 9'b111111_1_11);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        got = obs(i); want = exp_out(i); checks++;
        if (got !== want) begin
          errors++; $display("FAIL brake_hazard_seq inst%0d cyc%0d got %b want %b", i, k, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got;
    do_reset();
    in_l = 1; apply();
    step(); step(); step(); step(); step();
    got = obs(0); checks++;
    if (got !== 9'b111000_1_01) begin
      errors++; $display("FAIL reset_mid_l3 got %b want %b", got, 9'b111000_1_01);
    end
    in_rst = 1; apply();
    step();
    got = obs(0); checks++;
    if (got !== 9'b000000_0_00) begin
      errors++; $display("FAIL reset_mid_clear got %b want %b", got, 9'b000000_0_00);
    end
    in_rst = 0; apply();
    step();
    got = obs(0); checks++;
    if (got !== 9'b100000_1_01) begin
      errors++; $display("FAIL reset_mid_restart got %b want %b", got, 9'b100000_1_01);
    end
  endtask

  task automatic test_random();
    logic [8:0] got, want;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) in_l = ~in_l;
      if ($urandom_range(0, 7) == 0) in_r = ~in_r;
      if ($urandom_range(0, 15) == 0) in_h = ~in_h;
      if ($urandom_range(0, 9) == 0) in_b = ~in_b;
      in_rst = ($urandom_range(0, 99) == 0);
      apply();
      step();
      for (int i = 0; i < 2; i++) begin
        got = obs(i); want = exp_out(i); checks++;
        if (got !== want) begin
          errors++; $display("FAIL random inst%0d cyc%0d got %b want %b", i, k, got, want);
        end
      end
    end
    in_rst = 0; apply();
  endtask

  initial begin
    in_l = 0; in_r = 0; in_h = 0; in_b = 0; in_rst = 1;
    for (int i = 0; i < 2; i++) begin m_kind[i] = 0; m_pos[i] = 0; m_brake[i] = 0; end
    apply();
    @(negedge clk);
    test_reset();
    test_left();
    test_hazard_pair();
    test_preempt();
    test_brake();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
